vend_dispense_arbiter: RTL and testbench
========================================

VEND_DISPENSE_ARBITER -- requirements
Module: vend_dispense_arbiter

Interface
REQ-001 Parameter POUR_MAX, default 8: maximum POUR cycles before timeout; legal range 2..255.
REQ-002 Parameter COOL_CYCLES, default 2: dispenser recovery cycles after a completed pour; legal range 1..255.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-front-panel dispense request, level, bit i = panel i.
REQ-006 disp_done  input  1  dispenser pour-complete pulse.
REQ-007 fault_clr  input  1  operator clear for FAULT state.
REQ-008 gnt  output  2  one-hot grant, registered.
REQ-009 dispense  output  1  pour command to dispenser, registered.
REQ-010 ack  output  2  one-cycle completion pulse to the granted panel.
REQ-011 nak  output  2  one-cycle timeout pulse to the granted panel.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 fault  output  1  high only in FAULT.

Function
REQ-014 The FSM SHALL have five states: IDLE, GRANT, POUR, COOL, FAULT.
REQ-015 IDLE: if any req bit is high, go to GRANT and latch one winner; otherwise stay.
REQ-016 Arbitration SHALL be round-robin over a 1-bit last-served pointer; a single requester always wins.
REQ-017 When both requesters are active, the panel not equal to the pointer wins; the pointer updates to the winner on entry to GRANT.
REQ-018 GRANT lasts exactly one cycle, then goes to POUR; gnt is the winner's one-hot code from GRANT through POUR and 00 elsewhere.
REQ-019 POUR: dispense=1; an 8-bit pour counter clears on entry and increments each POUR cycle.
REQ-020 POUR + disp_done sampled high: go to COOL; ack[winner]=1 for the first COOL cycle only.
REQ-021 POUR + counter == POUR_MAX-1 + disp_done low: go to FAULT; nak[winner]=1 for the first FAULT cycle only.
REQ-022 If disp_done and timeout occur in the same cycle, disp_done wins: COOL with ack, no nak.
REQ-023 COOL lasts exactly COOL_CYCLES cycles, then goes to IDLE; requests are not sampled during COOL.
REQ-024 FAULT holds until fault_clr is sampled high, then goes to IDLE; the pointer is unchanged by FAULT.
REQ-025 disp_done outside POUR SHALL be ignored; fault_clr outside FAULT SHALL be ignored.
REQ-026 Deasserting req after GRANT SHALL NOT abort the transaction; req changes are examined only in IDLE.
REQ-027 ack and nak SHALL never both be nonzero, and are never asserted in the same cycle as gnt.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, pointer=1 (panel 0 wins first tie), counters=0, gnt=00, dispense=0, ack=00, nak=00, busy=0, fault=0.
REQ-030 Reset asserted mid-POUR SHALL drop dispense asynchronously and generate no ack or nak.

Verification
REQ-031 Single pour (POUR_MAX=8, COOL_CYCLES=2). Stimulus: req=01 sampled at edge k, disp_done high at edge k+4. Response: gnt=01 from k to k+4; dispense=1 from k+1 to k+4; ack=01 from k+4 to k+5; IDLE after edge k+6.
REQ-032 Tie fairness. Stimulus: req=11 held through three transactions after reset. Response: grants in the order 01, 10, 01.
REQ-033 Timeout. Stimulus: req=10 with no disp_done. Response: dispense high for exactly 8 cycles; nak=10 for one cycle; fault=1 until fault_clr; then busy=0.
REQ-034 Simultaneous done/timeout. Stimulus: disp_done on the 8th POUR cycle. Response: ack pulse, nak=00, fault=0.
REQ-035 Abort by reset. Stimulus: rst_n low on the 3rd POUR cycle. Response: dispense=0 and gnt=00 at once; no ack; the next tie goes to panel 0.
REQ-036 Spurious inputs. Stimulus: disp_done in IDLE/COOL, fault_clr in IDLE, req dropped during POUR. Response: no state change, and the pour completes normally.

Source files
------------

// File: rtl/vend_dispense_arbiter_if.sv
// Front-panel / dispenser signal bundle for the dispense arbiter.
// The master side drives requests and dispenser status; the slave side is the arbiter.
interface vend_dispense_arbiter_if;
  logic [1:0] req;
  logic       disp_done;
  logic       fault_clr;
  logic [1:0] gnt;
  logic       dispense;
  logic [1:0] ack;
  logic [1:0] nak;
  logic       busy;
  logic       fault;

  modport master (
    output req, disp_done, fault_clr,
    input  gnt, dispense, ack, nak, busy, fault
  );

  modport slave (
    input  req, disp_done, fault_clr,
    output gnt, dispense, ack, nak, busy, fault
  );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter sharing one dispenser between two front panels, with pour
// timeout, cool-down and operator-cleared fault. All outputs are registered.
module vend_dispense_arbiter #(
  parameter int unsigned POUR_MAX    = 8,
  parameter int unsigned COOL_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vend_dispense_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_POUR  = 3'd2,
    S_COOL  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [7:0] POUR_LAST = 8'(POUR_MAX - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOL_CYCLES - 1);

  state_t     state_q;
  logic       ptr_q;
  logic       win_q;
  logic [7:0] pour_cnt_q;
  logic [7:0] cool_cnt_q;
  logic [1:0] gnt_q;
  logic [1:0] ack_q;
  logic [1:0] nak_q;
  logic       dispense_q;
  logic       busy_q;
  logic       fault_q;

  logic       win_d;

  function automatic logic [1:0] onehot(input logic panel);
    return panel ? 2'b10 : 2'b01;
  endfunction

  // A lone requester wins outright; on a tie the panel not served last wins.
  always_comb begin
    win_d = bus.req[1];
    if (bus.req == 2'b11) begin
      win_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b1;
      win_q      <= 1'b0;
      pour_cnt_q <= 8'd0;
      cool_cnt_q <= 8'd0;
      gnt_q      <= 2'b00;
      ack_q      <= 2'b00;
      nak_q      <= 2'b00;
      dispense_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      nak_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            state_q <= S_GRANT;
            win_q   <= win_d;
            ptr_q   <= win_d;
            gnt_q   <= onehot(win_d);
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          state_q    <= S_POUR;
          pour_cnt_q <= 8'd0;
          dispense_q <= 1'b1;
        end
        S_POUR: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (bus.disp_done) begin
            state_q    <= S_COOL;
            cool_cnt_q <= 8'd0;
            gnt_q      <= 2'b00;
            dispense_q <= 1'b0;
            ack_q      <= onehot(win_q);
          end else if (pour_cnt_q == POUR_LAST) begin
            state_q    <= S_FAULT;
            gnt_q      <= 2'b00;
            dispense_q <= 1'b0;
            nak_q      <= onehot(win_q);
            fault_q    <= 1'b1;
          end else begin
            pour_cnt_q <= pour_cnt_q + 8'd1;
          end
        end
        S_COOL: begin
          if (cool_cnt_q == COOL_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cool_cnt_q <= cool_cnt_q + 8'd1;
          end
        end
        S_FAULT: begin
          if (bus.fault_clr) begin
            state_q <= S_IDLE;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          gnt_q      <= 2'b00;
          dispense_q <= 1'b0;
          busy_q     <= 1'b0;
          fault_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.dispense = dispense_q;
  assign bus.ack      = ack_q;
  assign bus.nak      = nak_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Randomized scoreboard bench for the dispense arbiter: stimulus pushes expected
// transaction outcomes, a negedge monitor pops them when ack/nak appears.
module tb_vend_dispense_arbiter;
  localparam int P = 8;
  localparam int C = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vend_dispense_arbiter_if bus();

  vend_dispense_arbiter #(.POUR_MAX(P), .COOL_CYCLES(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One expected transaction: winning panel, completion kind, pour length, GRANT cycle.
  typedef struct {
    int win;
    bit is_ack;
    int len;
    int k;
  } exp_t;

  exp_t sb[$];
  int   pushed      = 0;
  int   popped      = 0;
  int   last_served = 1;

  function automatic int model_pick(input logic [1:0] r);
    int w;
    if (r == 2'b11) w = (last_served == 0) ? 1 : 0;
    else            w = (r == 2'b10) ? 1 : 0;
    last_served = w;
    return w;
  endfunction

  // Monitor
  int         gcnt = 0, dcnt = 0, g_rise = 0, ack_cyc = 0;
  logic [1:0] g_val = 2'b00;
  bit         cool_pend = 0, prev_busy = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      gcnt = 0; dcnt = 0; cool_pend = 0; prev_busy = 0;
    end else begin
      chk("ack_nak_exclusive", int'((bus.ack != 0) && (bus.nak != 0)), 0);
      chk("gnt_with_pulse", int'((bus.gnt != 0) && ((bus.ack | bus.nak) != 0)), 0);
      chk("gnt_not_both", int'(bus.gnt == 2'b11), 0);
      chk("dispense_without_gnt", int'(bus.dispense && (bus.gnt == 0)), 0);
      chk("fault_without_busy", int'(bus.fault && !bus.busy), 0);
      if (bus.gnt != 0) begin
        if (gcnt == 0) begin
          g_rise = cyc;
          g_val  = bus.gnt;
        end else begin
          chk("gnt_stable", int'(bus.gnt), int'(g_val));
        end
        gcnt++;
      end
      if (bus.dispense) dcnt++;
      if ((bus.ack != 0) || (bus.nak != 0)) begin
        chk("outcome_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          int   code;
          e = sb.pop_front();
          popped++;
          code = (e.win == 1) ? 2 : 1;
          chk("gnt_code", int'(g_val), code);
          chk("gnt_start_cycle", g_rise, e.k);
          chk("gnt_cycles", gcnt, e.len + 1);
          chk("dispense_cycles", dcnt, e.len);
          chk("pulse_cycle", cyc, e.k + e.len + 1);
          if (e.is_ack) begin
            chk("ack_code", int'(bus.ack), code);
            chk("nak_on_done", int'(bus.nak), 0);
            chk("fault_on_done", int'(bus.fault), 0);
          end else begin
            chk("nak_code", int'(bus.nak), code);
            chk("ack_on_timeout", int'(bus.ack), 0);
            chk("fault_on_timeout", int'(bus.fault), 1);
          end
          cool_pend = e.is_ack;
          ack_cyc   = cyc;
        end
        gcnt = 0;
        dcnt = 0;
      end
      if (prev_busy && !bus.busy && cool_pend) begin
        chk("cool_length", cyc - ack_cyc, C);
        cool_pend = 0;
      end
      prev_busy = bus.busy;
    end
  end

  // Entered and left at a negedge where the DUT is idle. j = POUR cycle carrying
  // disp_done (1..P), or 0 for no disp_done (timeout).
  task automatic run_txn(input logic [1:0] r, input int j);
    int   k, w, len, n;
    exp_t e;
    n = $urandom_range(0, 2);
    repeat (n) begin
      bus.req       = 2'b00;
      bus.disp_done = 1'($urandom);
      bus.fault_clr = 1'($urandom);
      @(negedge clk);
      chk("idle_spurious_busy", int'(bus.busy), 0);
    end
    bus.req       = r;
    bus.disp_done = 1'b0;
    bus.fault_clr = 1'b0;
    @(negedge clk);
    k   = cyc;
    w   = model_pick(r);
    len = (j == 0) ? P : j;
    e.win = w; e.is_ack = (j != 0); e.len = len; e.k = k;
    sb.push_back(e);
    pushed++;
    bus.req       = 2'($urandom);
    bus.disp_done = 1'($urandom);
    for (int i = 2; i <= len + 1; i++) begin
      @(negedge clk);
      bus.req       = 2'($urandom);
      bus.disp_done = (j != 0) && (i == j + 1);
    end
    if (j != 0) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (bus.busy) begin
          bus.req       = 2'($urandom);
          bus.disp_done = 1'($urandom);
        end
      end while (bus.busy && n < 50);
      chk("return_to_idle", int'(bus.busy), 0);
    end else begin
      @(negedge clk);
      chk("timeout_fault", int'(bus.fault), 1);
      n = $urandom_range(0, 3);
      repeat (n) begin
        bus.req       = 2'($urandom);
        bus.disp_done = 1'($urandom);
        @(negedge clk);
        chk("fault_hold", int'(bus.fault), 1);
      end
      bus.fault_clr = 1'b1;
      @(negedge clk);
      bus.fault_clr = 1'b0;
      bus.disp_done = 1'b0;
      chk("fault_clr_fault", int'(bus.fault), 0);
      chk("fault_clr_busy", int'(bus.busy), 0);
    end
  endtask

  // Tie request aborted by reset during the third POUR cycle.
  task automatic run_abort();
    bus.req       = 2'b11;
    bus.disp_done = 1'b0;
    bus.fault_clr = 1'b0;
    @(negedge clk);
    bus.req = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_pre_dispense", int'(bus.dispense), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_dispense", int'(bus.dispense), 0);
    chk("abort_gnt", int'(bus.gnt), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ack", int'(bus.ack), 0);
    chk("abort_nak", int'(bus.nak), 0);
    last_served = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, sel, j;
    bus.req       = 2'b00;
    bus.disp_done = 1'b0;
    bus.fault_clr = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_dispense", int'(bus.dispense), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_nak", int'(bus.nak), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_fault", int'(bus.fault), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", int'(bus.busy), 0);

    repeat (3) run_txn(2'b11, $urandom_range(1, P));
    run_txn(2'b01, 3);
    run_txn(2'b10, 0);
    run_txn(2'b01, P);
    run_abort();
    run_txn(2'b11, 2);

    for (int t = 0; t < 40; t++) begin
      r   = $urandom_range(1, 3);
      sel = $urandom_range(0, 5);
      case (sel)
        0:       j = 0;
        1:       j = 1;
        2:       j = P;
        default: j = $urandom_range(1, P);
      endcase
      run_txn(2'(r), j);
    end

    bus.req = 2'b00;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("outcomes_seen", popped, pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
